// File: rtl/heap_dpram_pkg.sv
// Shared types and helpers for the heap sorter key RAM (heap_dpram).
package heap_dpram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Which source drives a port's q output.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_CORE,
    SEL_BYP
  } qsel_t;

  // Terminal value of the clear counter; the sweep clears two entries per cycle.
  function automatic int unsigned clear_last(input int unsigned addr_width);
    if (addr_width <= 1) return 0;
    return (32'd1 << (addr_width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/heap_dpram_core.sv
// Reset-less true dual-port array: write on edge, one registered read per port.
module heap_dpram_core #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  we_b,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Reads sample the array before this edge's writes (read-first).
  always_ff @(posedge clk) begin
    if (re_a) rdata_a <= mem[addr_a];
    if (re_b) rdata_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
  end

endmodule

// File: rtl/heap_dpram.sv
// Dual-port heap key RAM with reset/clear sweep, read-valid strobes and collision flag.
// Define HEAP_DPRAM_BYPASS_EN for write-first forwarding on cross-port same-address access.
module heap_dpram
  import heap_dpram_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 16,
  parameter int unsigned          ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  valid_b,
  output logic                  collision
);

  localparam int unsigned CW   = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam int unsigned LAST = clear_last(ADDR_WIDTH);

`ifdef HEAP_DPRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  state_t                state;
  logic [CW-1:0]         cnt;
  qsel_t                 sel_a, sel_b;
  logic [DATA_WIDTH-1:0] byp_data_a, byp_data_b;
  logic [DATA_WIDTH-1:0] core_q_a, core_q_b;
  logic [ADDR_WIDTH-1:0] clr_addr_a, clr_addr_b;

  logic clearing, acc, same, rd_a, rd_b, wr_a, wr_b, coll_now, byp_a, byp_b;
  logic                  core_we_a, core_we_b;
  logic [ADDR_WIDTH-1:0] core_addr_a, core_addr_b;
  logic [DATA_WIDTH-1:0] core_d_a, core_d_b;

  generate
    if (ADDR_WIDTH == 1) begin : g_clr_narrow
      assign clr_addr_a = 1'b0;
      assign clr_addr_b = 1'b1;
    end else begin : g_clr_wide
      assign clr_addr_a = {cnt, 1'b0};
      assign clr_addr_b = {cnt, 1'b1};
    end
  endgenerate

  always_comb begin
    clearing = (state == ST_CLEAR);
    acc      = (state == ST_RUN) && !rst && !clear;
    same     = en_a && en_b && (addr_a == addr_b);
    rd_a     = acc && en_a && !we_a;
    rd_b     = acc && en_b && !we_b;
    wr_a     = acc && en_a && we_a;
    // Port A wins a same-address write/write, so B's write is dropped.
    wr_b     = acc && en_b && we_b && !(same && we_a);
    coll_now = acc && same && (we_a || we_b);
    byp_a    = BYPASS && rd_a && same && we_b;
    byp_b    = BYPASS && rd_b && same && we_a;

    core_we_a   = clearing || wr_a;
    core_we_b   = clearing || wr_b;
    core_addr_a = clearing ? clr_addr_a : addr_a;
    core_addr_b = clearing ? clr_addr_b : addr_b;
    core_d_a    = clearing ? CLEAR_VALUE : data_a;
    core_d_b    = clearing ? CLEAR_VALUE : data_b;
  end

  heap_dpram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .we_a   (core_we_a),
    .re_a   (rd_a),
    .addr_a (core_addr_a),
    .wdata_a(core_d_a),
    .rdata_a(core_q_a),
    .we_b   (core_we_b),
    .re_b   (rd_b),
    .addr_b (core_addr_b),
    .wdata_b(core_d_b),
    .rdata_b(core_q_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      busy       <= 1'b1;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      collision  <= 1'b0;
      sel_a      <= SEL_ZERO;
      sel_b      <= SEL_ZERO;
      byp_data_a <= '0;
      byp_data_b <= '0;
    end else begin
      valid_a   <= rd_a;
      valid_b   <= rd_b;
      collision <= coll_now;
      if (rd_a) sel_a <= byp_a ? SEL_BYP : SEL_CORE;
      if (rd_b) sel_b <= byp_b ? SEL_BYP : SEL_CORE;
      if (byp_a) byp_data_a <= data_b;
      if (byp_b) byp_data_b <= data_a;
      case (state)
        ST_CLEAR: begin
          if (clear) begin
            cnt <= '0;
          end else if (cnt == CW'(LAST)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // q is a registered selection; the core register itself holds between reads.
  always_comb begin
    case (sel_a)
      SEL_CORE: q_a = core_q_a;
      SEL_BYP:  q_a = byp_data_a;
      default:  q_a = '0;
    endcase
    case (sel_b)
      SEL_CORE: q_b = core_q_b;
      SEL_BYP:  q_b = byp_data_b;
      default:  q_b = '0;
    endcase
  end

endmodule

// File: tb/tb_heap_dpram.sv
// Self-checking bench for heap_dpram: directed steps plus random traffic vs a behavioural model.
module tb_heap_dpram;

`ifdef HEAP_DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, busy;
  logic        en_a, we_a, valid_a, en_b, we_b, valid_b, collision;
  logic [4:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b, q_a, q_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [32];
  int          rem;
  logic [15:0] eq_a, eq_b;
  logic        ev_a, ev_b, ecol;

  always #5 clk = ~clk;

  heap_dpram #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (5),
    .CLEAR_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a), .valid_a(valid_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b), .valid_b(valid_b),
    .collision(collision)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the rules, compare all outputs.
  task automatic step(input bit r, input bit c,
                      input bit ea, input bit wa, input logic [4:0] aa, input logic [15:0] da,
                      input bit eb, input bit wb, input logic [4:0] ab, input logic [15:0] db);
    bit sm;
    rst = r; clear = c;
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    @(posedge clk); #1;
    if (r || c) begin
      for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
      rem = 16; ev_a = 0; ev_b = 0; ecol = 0;
      if (r) begin eq_a = 16'h0000; eq_b = 16'h0000; end
    end else if (rem > 0) begin
      rem--; ev_a = 0; ev_b = 0; ecol = 0;
    end else begin
      sm   = ea && eb && (aa == ab);
      ev_a = ea && !wa;
      ev_b = eb && !wb;
      ecol = sm && (wa || wb);
      if (ev_a) eq_a = (BYP && sm && wb) ? db : mem[aa];
      if (ev_b) eq_b = (BYP && sm && wa) ? da : mem[ab];
      if (eb && wb) mem[ab] = db;
      if (ea && wa) mem[aa] = da;
    end
    chk("busy", 32'(busy), 32'(rem > 0));
    chk("valid_a", 32'(valid_a), 32'(ev_a));
    chk("valid_b", 32'(valid_b), 32'(ev_b));
    chk("collision", 32'(collision), 32'(ecol));
    chk("q_a", 32'(q_a), 32'(eq_a));
    chk("q_b", 32'(q_b), 32'(eq_b));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0);
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    do begin
      idle();
      n++;
    end while (busy === 1'b1 && n < 40);
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    rst = 0; clear = 0; en_a = 0; we_a = 0; addr_a = '0; data_a = '0;
    en_b = 0; we_b = 0; addr_b = '0; data_b = '0;
    @(negedge clk);

    // Reset, sweep length, all entries read back as zero.
    step(1, 0, 0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    count_busy("busy_len_rst");
    for (int i = 0; i < 32; i += 2)
      step(0, 0, 1, 0, 5'(i), 16'h0, 1, 0, 5'(i + 1), 16'h0);
    chk("sweep_last_q_b", 32'(q_b), 32'h0);

    // Different-address writes, then cross reads.
    step(0, 0, 1, 1, 5'h1F, 16'h0055, 1, 1, 5'h1E, 16'h0066);
    step(0, 0, 1, 0, 5'h1E, 16'h0, 1, 0, 5'h1F, 16'h0);
    chk("xread_q_a", 32'(q_a), 32'h0066);
    chk("xread_q_b", 32'(q_b), 32'h0055);
    chk("xread_coll", 32'(collision), 32'd0);

    // Write/write collision: A wins.
    step(0, 0, 1, 1, 5'h0A, 16'h0042, 1, 1, 5'h0A, 16'h0038);
    chk("ww_coll", 32'(collision), 32'd1);
    idle();
    chk("ww_coll_pulse", 32'(collision), 32'd0);
    step(0, 0, 0, 0, 5'h0, 16'h0, 1, 0, 5'h0A, 16'h0);
    chk("ww_winner", 32'(q_b), 32'h0042);

    // Read/write collision, both directions.
    step(0, 0, 0, 0, 5'h0, 16'h0, 1, 1, 5'h15, 16'h0038);
    step(0, 0, 1, 1, 5'h15, 16'h0042, 1, 0, 5'h15, 16'h0);
    chk("rw_coll", 32'(collision), 32'd1);
    chk("rw_q_b", 32'(q_b), BYP ? 32'h0042 : 32'h0038);
    step(0, 0, 1, 0, 5'h15, 16'h0, 1, 1, 5'h15, 16'h0077);
    chk("wr_q_a", 32'(q_a), BYP ? 32'h0077 : 32'h0042);
    step(0, 0, 1, 0, 5'h15, 16'h0, 1, 0, 5'h15, 16'h0);
    chk("rr_coll", 32'(collision), 32'd0);
    chk("rr_q_a", 32'(q_a), 32'h0077);

    // Clear, re-clear mid-sweep with ignored accesses, then read back.
    step(0, 0, 1, 1, 5'h03, 16'h0055, 0, 0, 5'h0, 16'h0);
    step(0, 1, 0, 0, 5'h0, 16'h0, 0, 0, 5'h0, 16'h0);
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0, 5'h03, 16'h0, 1, 1, 5'(i), 16'hBEEF);
    chk("busy_access_valid", 32'(valid_a), 32'd0);
    step(0, 1, 0, 0, 5'h0, 16'h0, 0, 0, 5'h0, 16'h0);
    count_busy("busy_len_clear");
    step(0, 0, 1, 0, 5'h03, 16'h0, 1, 0, 5'h00, 16'h0);
    chk("clear_q_a", 32'(q_a), 32'h0);
    chk("clear_q_b", 32'(q_b), 32'h0);

    // Reset on the edge of a read drops it.
    step(0, 0, 1, 1, 5'h1F, 16'h1234, 0, 0, 5'h0, 16'h0);
    step(0, 0, 1, 0, 5'h1F, 16'h0, 0, 0, 5'h0, 16'h0);
    chk("pre_rst_q_a", 32'(q_a), 32'h1234);
    step(1, 0, 1, 0, 5'h1F, 16'h0, 0, 0, 5'h0, 16'h0);
    chk("rst_read_valid", 32'(valid_a), 32'd0);
    chk("rst_read_q", 32'(q_a), 32'h0);
    count_busy("busy_len_rst2");

    // Random traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      bit          r, c;
      logic [4:0]  aa, ab;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 79) == 0);
      aa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      step(r, c, 1'($urandom), 1'($urandom), aa, 16'($urandom),
           1'($urandom), 1'($urandom), ab, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
